// File: rtl/sys_defs_pkg.sv
// Shared machine-wide definitions: datapath widths, ALU opcodes, the packet
// handed from a reservation station to its functional unit, and the ALU
// reservation-station entry layout.

`ifndef XLEN
`define XLEN 32
`endif

`ifndef PRF_LEN
`define PRF_LEN 6
`endif

`ifndef ROB_LEN
`define ROB_LEN 5
`endif

package sys_defs;

    localparam int XLEN_W = `XLEN;
    localparam int PRF_W  = `PRF_LEN;
    localparam int ROB_W  = `ROB_LEN;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_SLT  = 4'h2,
        ALU_SLTU = 4'h3,
        ALU_AND  = 4'h4,
        ALU_OR   = 4'h5,
        ALU_XOR  = 4'h6,
        ALU_SLL  = 4'h7,
        ALU_SRL  = 4'h8,
        ALU_SRA  = 4'h9
    } ALU_FUNC;

    typedef struct packed {
        logic [XLEN_W-1:0] opa_value;
        logic [XLEN_W-1:0] opb_value;
        logic [PRF_W-1:0]  dest_preg_idx;
        logic [ROB_W-1:0]  rob_index;
        ALU_FUNC           alu_func;
    } RS_FU_PACKET;

    typedef struct packed {
        logic              valid;
        logic              opa_ready;
        logic [XLEN_W-1:0] opa_value;
        logic [PRF_W-1:0]  opa_preg;
        logic              opb_ready;
        logic [XLEN_W-1:0] opb_value;
        logic [PRF_W-1:0]  opb_preg;
        logic [PRF_W-1:0]  dest_preg_idx;
        logic [ROB_W-1:0]  rob_index;
        ALU_FUNC           alu_func;
    } RS_ALU_ENTRY;

    // True when a valid CDB broadcast carries the tag an operand waits on.
    function automatic logic tag_match(
        input logic             bus_valid,
        input logic [PRF_W-1:0] bus_tag,
        input logic [PRF_W-1:0] preg
    );
        return bus_valid && (bus_tag == preg);
    endfunction

    // Strip the bookkeeping fields off an entry to form the issue packet.
    function automatic RS_FU_PACKET entry_to_packet(input RS_ALU_ENTRY e);
        RS_FU_PACKET p;
        p.opa_value     = e.opa_value;
        p.opb_value     = e.opb_value;
        p.dest_preg_idx = e.dest_preg_idx;
        p.rob_index     = e.rob_index;
        p.alu_func      = e.alu_func;
        return p;
    endfunction

endpackage

// File: rtl/ps_lowest.sv
// Lowest-index priority selector: one-hot grant of the lowest set request bit,
// plus a flag that is high when any request bit is set.

module ps_lowest #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] gnt,
    output logic             any
);

    // Scan upward from bit 0 and pass only the first set request.
    always_comb begin
        logic seen;
        seen = 1'b0;
        gnt  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            gnt[i] = req[i] & ~seen;
            seen   = seen | req[i];
        end
    end

    assign any = |req;

endmodule

// File: rtl/rs_alu.sv
// Reservation station for the single-cycle integer ALU. Holds dispatched
// instructions until both operands are captured (at dispatch, by same-cycle
// CDB bypass, or by later CDB wakeup) and issues the lowest-index ready entry
// each cycle through a registered packet.
//
// Handshake: dispatch_valid is a request with no ready return; it is accepted
// at the edge only when rs_alu_full is low and flush is low, otherwise it is
// dropped. alu_enable qualifies rs_fu_packet for exactly the cycle it is high;
// the ALU always accepts, so issue never stalls.

module rs_alu
    import sys_defs::*;
#(
    parameter int RS_SIZE = 8
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              dispatch_valid,
    input  logic              dispatch_opa_ready,
    input  logic [XLEN_W-1:0] dispatch_opa_value,
    input  logic [PRF_W-1:0]  dispatch_opa_preg,
    input  logic              dispatch_opb_ready,
    input  logic [XLEN_W-1:0] dispatch_opb_value,
    input  logic [PRF_W-1:0]  dispatch_opb_preg,
    input  logic [PRF_W-1:0]  dispatch_dest_preg_idx,
    input  logic [ROB_W-1:0]  dispatch_rob_index,
    input  ALU_FUNC           dispatch_alu_func,

    input  logic              cdb_valid,
    input  logic [PRF_W-1:0]  cdb_preg_idx,
    input  logic [XLEN_W-1:0] cdb_value,

    input  logic              flush,

    output logic              rs_alu_full,
    output RS_FU_PACKET       rs_fu_packet,
    output logic              alu_enable
);

    RS_ALU_ENTRY               entries      [RS_SIZE];
    RS_ALU_ENTRY               entries_next [RS_SIZE];
    RS_ALU_ENTRY               dispatch_entry;
    RS_FU_PACKET               issue_packet;

    logic [RS_SIZE-1:0]        valid_vec;
    logic [RS_SIZE-1:0]        ready_vec;
    logic [RS_SIZE-1:0]        free_onehot;
    logic [RS_SIZE-1:0]        issue_onehot;
    logic                      free_any;
    logic                      issue_any;
    logic                      dispatch_fire;

    // Per-entry status vectors seen by the two selectors.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            valid_vec[i] = entries[i].valid;
            ready_vec[i] = entries[i].valid & entries[i].opa_ready & entries[i].opb_ready;
        end
    end

    ps_lowest #(.WIDTH(RS_SIZE)) u_free_sel (
        .req (~valid_vec),
        .gnt (free_onehot),
        .any (free_any)
    );

    ps_lowest #(.WIDTH(RS_SIZE)) u_issue_sel (
        .req (ready_vec),
        .gnt (issue_onehot),
        .any (issue_any)
    );

    // Full reflects only register state, so a slot freed by this cycle's
    // issue shows up as free one cycle later.
    assign rs_alu_full   = ~free_any;
    assign dispatch_fire = dispatch_valid & ~rs_alu_full & ~flush;

    // Build the entry to be written on dispatch, including same-cycle CDB bypass.
    always_comb begin
        dispatch_entry               = '0;
        dispatch_entry.valid         = 1'b1;
        dispatch_entry.opa_ready     = dispatch_opa_ready;
        dispatch_entry.opa_value     = dispatch_opa_value;
        dispatch_entry.opa_preg      = dispatch_opa_preg;
        dispatch_entry.opb_ready     = dispatch_opb_ready;
        dispatch_entry.opb_value     = dispatch_opb_value;
        dispatch_entry.opb_preg      = dispatch_opb_preg;
        dispatch_entry.dest_preg_idx = dispatch_dest_preg_idx;
        dispatch_entry.rob_index     = dispatch_rob_index;
        dispatch_entry.alu_func      = dispatch_alu_func;
        if (!dispatch_opa_ready && tag_match(cdb_valid, cdb_preg_idx, dispatch_opa_preg)) begin
            dispatch_entry.opa_ready = 1'b1;
            dispatch_entry.opa_value = cdb_value;
        end
        if (!dispatch_opb_ready && tag_match(cdb_valid, cdb_preg_idx, dispatch_opb_preg)) begin
            dispatch_entry.opb_ready = 1'b1;
            dispatch_entry.opb_value = cdb_value;
        end
    end

    // Next entry contents: flush clears, issue frees, wakeup captures, dispatch fills.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            entries_next[i] = entries[i];
            if (flush) begin
                entries_next[i].valid = 1'b0;
            end else if (issue_onehot[i]) begin
                entries_next[i] = '0;
            end else if (entries[i].valid) begin
                if (!entries[i].opa_ready &&
                    tag_match(cdb_valid, cdb_preg_idx, entries[i].opa_preg)) begin
                    entries_next[i].opa_ready = 1'b1;
                    entries_next[i].opa_value = cdb_value;
                end
                if (!entries[i].opb_ready &&
                    tag_match(cdb_valid, cdb_preg_idx, entries[i].opb_preg)) begin
                    entries_next[i].opb_ready = 1'b1;
                    entries_next[i].opb_value = cdb_value;
                end
            end else if (dispatch_fire && free_onehot[i]) begin
                entries_next[i] = dispatch_entry;
            end
        end
    end

    // Mux the selected winner's fields into the packet to be registered.
    always_comb begin
        issue_packet = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (issue_onehot[i]) begin
                issue_packet = entry_to_packet(entries[i]);
            end
        end
    end

    // Entry storage; reset clears every field, including valid and ready bits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entries[i] <= entries_next[i];
            end
        end
    end

    // Registered issue port; the packet holds its last value when idle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alu_enable   <= 1'b0;
            rs_fu_packet <= '0;
        end else if (flush) begin
            alu_enable   <= 1'b0;
        end else begin
            alu_enable   <= issue_any;
            if (issue_any) begin
                rs_fu_packet <= issue_packet;
            end
        end
    end

endmodule
